// File: rtl/uart_pkg.sv
// Frame layout and receiver state encoding shared by the UART transmit and receive paths.
package uart_pkg;

    localparam int UART_FRAME_W = 11;

    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_deserialize.sv
// Oversampling UART receiver: mid-bit sampling of an 11-bit frame, parity/stop checking,
// and a valid/ready output register that holds one frame for the consumer.
module uart_deserialize
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_stream,
    output logic [7:0]              rx_data,
    output logic [UART_FRAME_W-1:0] rx_packet,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overrun,
    output logic                    busy
);

    localparam int               CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic             ODD_SEL  = (PARITY_ODD != 0);

    function automatic logic parity_mismatch(input logic [UART_FRAME_W-1:0] frame);
        return (^frame[PARITY_IDX:DATA_LSB]) != ODD_SEL;
    endfunction

    logic                    rxs;
    uart_rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic                    armed_q, armed_d;
    logic                    smp_en;
    logic [3:0]              smp_idx;
    logic                    done_p0;
    logic                    done_p1;
    logic [UART_FRAME_W-1:0] shift_p0;

    uart_rx_sync #(
        .STAGES(2)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (uart_stream),
        .q    (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        smp_en  = 1'b0;
        smp_idx = idx_q;
        done_p0 = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a high-to-low transition starts a frame, so a held break never retriggers.
                if (armed_q && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (rxs) begin
                    armed_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 4'(DATA_LSB);
                        smp_en  = 1'b1;
                        smp_idx = 4'(START_IDX);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    smp_en = 1'b1;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'(PARITY_IDX)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    smp_en  = 1'b1;
                    done_p0 = 1'b1;
                    armed_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage p0: mid-bit samples assembled into the frame shift register.
    always_ff @(posedge clk) begin
        if (smp_en) begin
            shift_p0[smp_idx] <= rxs;
        end
    end

    // Stage p1: completed frame moves into the consumer-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_p1    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_packet  <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_p1 <= done_p0;
            overrun <= done_p1 && rx_valid && !rx_ready;
            if (done_p1) begin
                rx_valid   <= 1'b1;
                rx_packet  <= shift_p0;
                rx_data    <= shift_p0[DATA_MSB:DATA_LSB];
                parity_err <= parity_mismatch(shift_p0);
                frame_err  <= ~shift_p0[STOP_IDX];
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
